mbe_div_seq: RTL and testbench
==============================

Name: mbe_div_seq

Overview:
- Sequential unsigned radix-2 non-restoring divider; the inverse operation to the MBE multiplier.
- Multiplier products can be fed back through it to recover an operand; it also forms the divide half of the lab arithmetic datapath.
- Valid/ready handshake on both sides; one division in flight at a time.
- DWIDTH-bit operands, DWIDTH-bit quotient and remainder.

Parameters:
- DWIDTH, 11, operand/quotient/remainder width (must be >= 2)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous reset, active-high
- dividend_i  in  DWIDTH  dividend
- divisor_i  in  DWIDTH  divisor
- in_valid_i  in  1  operands valid
- in_ready_o  out  1  divider can accept operands
- quotient_o  out  DWIDTH  quotient
- remainder_o  out  DWIDTH  remainder
- div_by_zero_o  out  1  result produced by a zero divisor
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts result

Behaviour:
- Reset (async assert, sync release): state IDLE; in_ready_o=1; out_valid_o=0; quotient_o, remainder_o, div_by_zero_o = 0; iteration counter = 0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready_o=1. On in_valid_i, latch the operands.
    - divisor != 0: go to BUSY, counter = DWIDTH-1.
    - divisor == 0: go straight to DONE.
  - BUSY: in_ready_o=0. Each cycle performs one non-restoring step on the DWIDTH+1-bit signed partial remainder:
    - shift left by 1, bringing in the next dividend MSB;
    - add the divisor if the partial remainder is negative, otherwise subtract it;
    - the quotient bit is the inverted sign of the result.
    - When counter == 0, apply the correction step (partial remainder negative -> add divisor back) in the same cycle, then go to DONE. Otherwise decrement the counter.
  - DONE: out_valid_o=1; outputs stable while out_ready_i=0. On out_ready_i, go to IDLE.
- in_ready_o is 0 in DONE: no operand accepted while a result is pending. No IDLE bypass.
- Latency: operands accepted in cycle 0 -> out_valid_o high in cycle DWIDTH+1.
  - Zero divisor: out_valid_o high in cycle 1.
- Zero divisor result: quotient_o = all ones, remainder_o = dividend, div_by_zero_o = 1.
  - div_by_zero_o is 0 for every other result.
- Invariant: dividend == quotient*divisor + remainder, with remainder < divisor.
- Outputs are registered and change only on the transition into DONE.
- Reset asserted mid-BUSY or mid-DONE aborts the operation, discards the result, and returns to the reset values.
- in_valid_i outside IDLE is ignored; operands are sampled only on the handshake.
- Dividend < divisor -> quotient 0, remainder = dividend, full latency (no early exit).

Optional Feature:
- MBE_DIV_SIGNED_EN
  - Defined: operands are two's complement.
    - Magnitudes are divided by the unsigned core; the quotient is negated when the operand signs differ.
    - Remainder takes the sign of the dividend (truncation toward zero).
    - Overflow case -2^(DWIDTH-1) / -1 -> quotient -2^(DWIDTH-1), remainder 0, div_by_zero_o=0.
    - Zero divisor -> quotient all ones (-1), remainder = dividend.
    - One extra cycle is spent in a FIX state between BUSY and DONE for sign correction, so latency is DWIDTH+2.
  - Undefined: unsigned only, no FIX state, latency DWIDTH+1.

Decomposition:
- Package mbe_div_pkg:
  - state enum div_state_e (IDLE, BUSY, FIX, DONE; FIX present unconditionally);
  - DIV_DWIDTH_DEFAULT = 11;
  - function cnt_w(DWIDTH) = $clog2(DWIDTH) for sizing the counter.
- Sub-module mbe_div_step: purely combinational single non-restoring step.
  - Inputs: partial remainder, divisor, incoming bit.
  - Outputs: next partial remainder, quotient bit.
  - Instantiated once in mbe_div_seq.
- A wrapper binding mbe_div_seq to a div_if interface lives in tb, alongside the multiplier wrapper.

Test Plan:
- Unsigned, DWIDTH=11: 1000/7 with out_ready_i=1 -> quotient 142, remainder 6, div_by_zero_o=0, out_valid_o exactly 12 cycles after accept.
- Edge values: 2047/1 -> 2047, 0; 5/2047 -> 0, 5; 2047/2047 -> 1, 0; 0/13 -> 0, 0.
- Zero divisor: 123/0 -> quotient 2047, remainder 123, div_by_zero_o=1, out_valid_o 1 cycle after accept.
- Backpressure: 1000/7 with out_ready_i held 0 for 5 cycles after out_valid_o:
  - outputs hold 142/6;
  - in_ready_o stays 0;
  - a second in_valid_i in that window is ignored;
  - accepted only after return to IDLE.
- Reset mid-operation: rst_i pulsed 4 cycles after accept -> out_valid_o=0, in_ready_o=1, all outputs 0 immediately; a following 100/9 returns 11, 1.
- MBE_DIV_SIGNED_EN:
  - -1000/7 -> quotient 1906 (-142), remainder 2042 (-6), latency 13;
  - 1024/2047 (-1024/-1) -> quotient 1024, remainder 0;
  - 1000/2041 (1000/-7) -> quotient 1906, remainder 6.

Source files
------------

// File: rtl/mbe_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mbe_div_pkg
//  Description : Shared types and helpers for the sequential radix-2
//                non-restoring divider (mbe_div_seq).
//                  - div_state_e : controller states (FIX is always declared
//                                  so that the type is the same in both
//                                  signed and unsigned builds)
//                  - DIV_DWIDTH_DEFAULT : default operand width
//                  - cnt_w()     : iteration counter width for a given DWIDTH
//  Revision    : 1.0  - initial release
// ============================================================================
package mbe_div_pkg;

    localparam int DIV_DWIDTH_DEFAULT = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    // The counter only needs to hold DWIDTH-1 down to 0.
    function automatic int cnt_w(input int dwidth);
        return $clog2(dwidth);
    endfunction

endpackage : mbe_div_pkg
`default_nettype wire

// File: rtl/mbe_div_step.sv
`default_nettype none
// ============================================================================
//  Module      : mbe_div_step
//  Description : One combinational radix-2 non-restoring division step.
//                The partial remainder is DWIDTH+1 bits, two's complement.
//                It is shifted left by one with i_bit brought in at the LSB,
//                then the divisor is added if the incoming partial remainder
//                was negative, otherwise subtracted. The quotient bit is the
//                inverted sign of the result.
//  Ports       : i_prem    [DWIDTH:0]   current partial remainder
//                i_divisor [DWIDTH-1:0] divisor (unsigned magnitude)
//                i_bit                  next dividend bit (MSB first)
//                o_prem    [DWIDTH:0]   next partial remainder
//                o_qbit                 quotient bit for this step
//  Revision    : 1.0  - initial release
// ============================================================================
module mbe_div_step #(
    parameter int DWIDTH = 11
) (
    input  logic [DWIDTH:0]   i_prem,
    input  logic [DWIDTH-1:0] i_divisor,
    input  logic              i_bit,
    output logic [DWIDTH:0]   o_prem,
    output logic              o_qbit
);

    logic [DWIDTH:0] w_shift;
    logic [DWIDTH:0] w_dvs_ext;

    assign w_shift   = {i_prem[DWIDTH-1:0], i_bit};
    assign w_dvs_ext = {1'b0, i_divisor};

    // The shifted value may wrap in DWIDTH+1 bits, but the add/subtract
    // result always lies in [-divisor, divisor) and is therefore exact
    // modulo 2^(DWIDTH+1).
    always_comb begin
        o_prem = w_shift - w_dvs_ext;
        if (i_prem[DWIDTH]) begin
            o_prem = w_shift + w_dvs_ext;
        end
        o_qbit = ~o_prem[DWIDTH];
    end

endmodule : mbe_div_step
`default_nettype wire

// File: rtl/mbe_div_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mbe_div_seq
//  Description : Sequential radix-2 non-restoring divider with valid/ready
//                handshakes on input and output, one division in flight.
//                Unsigned build: latency DWIDTH+1 cycles from accept to
//                out_valid_o (1 cycle for a zero divisor).
//                Optional macro MBE_DIV_SIGNED_EN: two's-complement operands,
//                magnitudes divided by the unsigned core, sign correction in
//                an extra FIX cycle (latency DWIDTH+2), truncation toward 0.
//                Zero divisor: quotient all ones, remainder = dividend,
//                div_by_zero_o = 1.
//  Ports       : clk_i, rst_i (async, active-high)
//                dividend_i, divisor_i, in_valid_i, in_ready_o  - operand side
//                quotient_o, remainder_o, div_by_zero_o,
//                out_valid_o, out_ready_i                        - result side
//  Revision    : 1.0  - initial release
// ============================================================================
module mbe_div_seq
    import mbe_div_pkg::*;
#(
    parameter int DWIDTH = DIV_DWIDTH_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DWIDTH-1:0] dividend_i,
    input  logic [DWIDTH-1:0] divisor_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [DWIDTH-1:0] quotient_o,
    output logic [DWIDTH-1:0] remainder_o,
    output logic              div_by_zero_o,
    output logic              out_valid_o,
    input  logic              out_ready_i
);

    localparam int CW = cnt_w(DWIDTH);

    div_state_e        r_state;
    div_state_e        w_state_nxt;

    logic [CW-1:0]     r_cnt;
    logic [DWIDTH:0]   r_rem;      // signed partial remainder
    logic [DWIDTH-1:0] r_quo;      // quotient bits shifted in MSB first
    logic [DWIDTH-1:0] r_dvd;      // dividend shifter, MSB feeds the step
    logic [DWIDTH-1:0] r_dvs;
    logic [DWIDTH-1:0] r_quotient;
    logic [DWIDTH-1:0] r_remainder;
    logic              r_dbz;

    logic              w_dvs_zero;
    logic              w_last;
    logic [DWIDTH-1:0] w_dvd_mag;
    logic [DWIDTH-1:0] w_dvs_mag;
    logic [DWIDTH:0]   w_prem_nxt;
    logic              w_qbit;
    logic [DWIDTH:0]   w_rem_fin;
    logic [DWIDTH-1:0] w_quo_fin;

`ifdef MBE_DIV_SIGNED_EN
    logic              r_dvd_neg;
    logic              r_quo_neg;

    // Negating -2^(DWIDTH-1) yields the same bit pattern, which read as
    // unsigned is exactly its magnitude, so no special case is needed.
    assign w_dvd_mag = dividend_i[DWIDTH-1] ? (~dividend_i + 1'b1) : dividend_i;
    assign w_dvs_mag = divisor_i[DWIDTH-1]  ? (~divisor_i + 1'b1)  : divisor_i;
`else
    assign w_dvd_mag = dividend_i;
    assign w_dvs_mag = divisor_i;
`endif

    assign w_dvs_zero = (divisor_i == '0);
    assign w_last     = (r_cnt == '0);

    mbe_div_step #(
        .DWIDTH    (DWIDTH)
    ) u_step (
        .i_prem    (r_rem),
        .i_divisor (r_dvs),
        .i_bit     (r_dvd[DWIDTH-1]),
        .o_prem    (w_prem_nxt),
        .o_qbit    (w_qbit)
    );

    // Final correction on the last iteration: a negative partial remainder
    // gets the divisor added back.
    assign w_rem_fin = w_prem_nxt[DWIDTH] ? (w_prem_nxt + {1'b0, r_dvs}) : w_prem_nxt;
    assign w_quo_fin = {r_quo[DWIDTH-2:0], w_qbit};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid_i) begin
                    w_state_nxt = w_dvs_zero ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (w_last) begin
`ifdef MBE_DIV_SIGNED_EN
                    w_state_nxt = FIX;
`else
                    w_state_nxt = DONE;
`endif
                end
            end
`ifdef MBE_DIV_SIGNED_EN
            FIX: begin
                w_state_nxt = DONE;
            end
`endif
            DONE: begin
                if (out_ready_i) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
`ifdef MBE_DIV_SIGNED_EN
            r_dvd_neg   <= 1'b0;
            r_quo_neg   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid_i) begin
                        if (w_dvs_zero) begin
                            r_quotient  <= '1;
                            r_remainder <= dividend_i;
                            r_dbz       <= 1'b1;
                        end else begin
                            r_cnt <= CW'(DWIDTH - 1);
                            r_rem <= '0;
                            r_quo <= '0;
                            r_dvd <= w_dvd_mag;
                            r_dvs <= w_dvs_mag;
`ifdef MBE_DIV_SIGNED_EN
                            r_dvd_neg <= dividend_i[DWIDTH-1];
                            r_quo_neg <= dividend_i[DWIDTH-1] ^ divisor_i[DWIDTH-1];
`endif
                        end
                    end
                end
                BUSY: begin
                    r_dvd <= {r_dvd[DWIDTH-2:0], 1'b0};
                    if (w_last) begin
`ifdef MBE_DIV_SIGNED_EN
                        r_rem <= w_rem_fin;
                        r_quo <= w_quo_fin;
`else
                        r_rem       <= w_rem_fin;
                        r_quo       <= w_quo_fin;
                        r_quotient  <= w_quo_fin;
                        r_remainder <= w_rem_fin[DWIDTH-1:0];
                        r_dbz       <= 1'b0;
`endif
                    end else begin
                        r_rem <= w_prem_nxt;
                        r_quo <= w_quo_fin;
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
`ifdef MBE_DIV_SIGNED_EN
                FIX: begin
                    r_quotient  <= r_quo_neg ? (~r_quo + 1'b1) : r_quo;
                    r_remainder <= r_dvd_neg ? (~r_rem[DWIDTH-1:0] + 1'b1)
                                             : r_rem[DWIDTH-1:0];
                    r_dbz       <= 1'b0;
                end
`endif
                default: begin
                end
            endcase
        end
    end

    assign in_ready_o    = (r_state == IDLE);
    assign out_valid_o   = (r_state == DONE);
    assign quotient_o    = r_quotient;
    assign remainder_o   = r_remainder;
    assign div_by_zero_o = r_dbz;

endmodule : mbe_div_seq
`default_nettype wire

// File: tb/tb_mbe_div_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mbe_div_seq
//  Description : Directed self-checking bench for mbe_div_seq (DWIDTH=11).
//                With MBE_DIV_SIGNED_EN defined, the signed vectors and the
//                DWIDTH+2 latency are used instead of the unsigned edge set.
//  Revision    : 1.0  - initial release
// ============================================================================
module tb_mbe_div_seq;

    localparam int DW = 11;
`ifdef MBE_DIV_SIGNED_EN
    localparam int LAT = DW + 2;
`else
    localparam int LAT = DW + 1;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [DW-1:0] dividend_i = '0;
    logic [DW-1:0] divisor_i = '0;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [DW-1:0] quotient_o;
    logic [DW-1:0] remainder_o;
    logic          div_by_zero_o;
    logic          out_valid_o;
    logic          out_ready_i = 1'b1;

    int checks = 0;
    int failures = 0;

    mbe_div_seq #(.DWIDTH(DW)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .dividend_i    (dividend_i),
        .divisor_i     (divisor_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .quotient_o    (quotient_o),
        .remainder_o   (remainder_o),
        .div_by_zero_o (div_by_zero_o),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present operands for one cycle; returns #1 after the accept edge.
    task automatic start(input logic [DW-1:0] dvd, input logic [DW-1:0] dvs, input string tag);
        @(negedge clk_i);
        dividend_i = dvd;
        divisor_i  = dvs;
        in_valid_i = 1'b1;
        chk({tag, "_in_ready"}, 32'(in_ready_o), 32'd1);
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
    endtask

    // Counts cycles from the accept edge until out_valid_o, bounded.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid_o && lat < 60) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
    endtask

    task automatic do_div(input logic [DW-1:0] dvd, input logic [DW-1:0] dvs,
                          input int q, input int r, input int dbz, input int lat_exp,
                          input string tag);
        int lat;
        out_ready_i = 1'b1;
        start(dvd, dvs, tag);
        wait_valid(lat);
        chk({tag, "_valid"}, 32'(out_valid_o), 32'd1);
        chk({tag, "_lat"}, 32'(lat), 32'(lat_exp));
        chk({tag, "_q"}, 32'(quotient_o), 32'(q));
        chk({tag, "_r"}, 32'(remainder_o), 32'(r));
        chk({tag, "_dbz"}, 32'(div_by_zero_o), 32'(dbz));
        @(posedge clk_i);
        #1;
        chk({tag, "_idle"}, 32'(in_ready_o), 32'd1);
    endtask

    initial begin
        int lat;

        // Reset state
        #1;
        chk("rst_in_ready", 32'(in_ready_o), 32'd1);
        chk("rst_out_valid", 32'(out_valid_o), 32'd0);
        chk("rst_q", 32'(quotient_o), 32'd0);
        chk("rst_r", 32'(remainder_o), 32'd0);
        chk("rst_dbz", 32'(div_by_zero_o), 32'd0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;

        do_div(11'd1000, 11'd7, 142, 6, 0, LAT, "d1000_7");
        do_div(11'd123, 11'd0, 2047, 123, 1, 1, "dzero");
`ifdef MBE_DIV_SIGNED_EN
        do_div(11'd1048, 11'd7, 1906, 2042, 0, LAT, "sneg1000_7");
        do_div(11'd1024, 11'd2047, 1024, 0, 0, LAT, "sovf");
        do_div(11'd1000, 11'd2041, 1906, 6, 0, LAT, "s1000_neg7");
`else
        do_div(11'd2047, 11'd1, 2047, 0, 0, LAT, "d2047_1");
        do_div(11'd5, 11'd2047, 0, 5, 0, LAT, "d5_2047");
        do_div(11'd2047, 11'd2047, 1, 0, 0, LAT, "d2047_2047");
        do_div(11'd0, 11'd13, 0, 0, 0, LAT, "d0_13");
`endif

        // Backpressure: result held, second request ignored until IDLE
        out_ready_i = 1'b0;
        start(11'd1000, 11'd7, "bp");
        wait_valid(lat);
        chk("bp_valid", 32'(out_valid_o), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            dividend_i = 11'd50;
            divisor_i  = 11'd5;
            in_valid_i = 1'b1;
            @(posedge clk_i);
            #1;
            chk("bp_hold_valid", 32'(out_valid_o), 32'd1);
            chk("bp_hold_q", 32'(quotient_o), 32'd142);
            chk("bp_hold_r", 32'(remainder_o), 32'd6);
            chk("bp_in_ready", 32'(in_ready_o), 32'd0);
        end
        @(negedge clk_i);
        out_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("bp_rel_valid", 32'(out_valid_o), 32'd0);
        chk("bp_rel_ready", 32'(in_ready_o), 32'd1);
        chk("bp_rel_q", 32'(quotient_o), 32'd142);
        @(posedge clk_i);   // in_valid_i still high: 50/5 accepted here
        #1;
        in_valid_i = 1'b0;
        chk("bp2_busy", 32'(in_ready_o), 32'd0);
        wait_valid(lat);
        chk("bp2_valid", 32'(out_valid_o), 32'd1);
        chk("bp2_lat", 32'(lat), 32'(LAT));
        chk("bp2_q", 32'(quotient_o), 32'd10);
        chk("bp2_r", 32'(remainder_o), 32'd0);
        @(posedge clk_i);
        #1;

        // Reset in the middle of a division
        start(11'd1000, 11'd7, "rmid");
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        chk("rmid_out_valid", 32'(out_valid_o), 32'd0);
        chk("rmid_in_ready", 32'(in_ready_o), 32'd1);
        chk("rmid_q", 32'(quotient_o), 32'd0);
        chk("rmid_r", 32'(remainder_o), 32'd0);
        chk("rmid_dbz", 32'(div_by_zero_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        do_div(11'd100, 11'd9, 11, 1, 0, LAT, "d100_9");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mbe_div_seq
`default_nettype wire
